hms_timekeeper: RTL and testbench

- Parametrised, fully synchronous hour:minute:second timekeeper for the FND digital-clock top level.
- Replaces ripple-clocked per-field counters with a single `clk` domain:
  - an internal prescaler generates a one-cycle second strobe;
  - fields update through clock enables.
- Provides CLOCK and SETUP modes, three-position field selection and configurable hour wrap.
- Drives the digit-split/decoder/display chain; button pulses arrive already debounced and edge-detected.

---
 rtl/hms_timekeeper.sv | 211 +++++++++++++++++++++
 tb/tb_hms_timekeeper.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hms_timekeeper.sv
// Single-clock hour:minute:second timekeeper with a second prescaler, CLOCK/SETUP modes and field editing.
// Define HMS_ALARM_EN to add the ALARM_SET mode, alarm registers and the o_alarm flag.
module hms_timekeeper #(
  parameter int CLK_DIV  = 50000000,
  parameter int HOUR_MAX = 23,
  parameter int SEC_INIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_mode_pulse,
  input  logic       i_pos_pulse,
  input  logic       i_inc_pulse,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [5:0] o_hour,
`ifdef HMS_ALARM_EN
  output logic [1:0] o_mode,
`else
  output logic       o_mode,
`endif
  output logic [1:0] o_position,
  output logic       o_sec_tick,
`ifdef HMS_ALARM_EN
  output logic       o_blink,
  output logic [5:0] o_alm_hour,
  output logic [5:0] o_alm_min,
  output logic [0:0] o_alarm
`else
  output logic       o_blink
`endif
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_DIV / 2 - 1);
  localparam logic [5:0]    HOUR_LAST  = 6'(HOUR_MAX);

`ifdef HMS_ALARM_EN
  typedef enum logic [1:0] {MODE_CLOCK = 2'd0, MODE_SETUP = 2'd1, MODE_ALARM = 2'd2} mode_e;
`else
  typedef enum logic {MODE_CLOCK = 1'b0, MODE_SETUP = 1'b1} mode_e;
`endif

  mode_e         mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          blink_q, blink_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    hour_q, hour_d;
  logic [1:0]    pos_q, pos_d;
  logic          time_run;
`ifdef HMS_ALARM_EN
  logic [5:0]    alm_min_q, alm_min_d;
  logic [5:0]    alm_hour_q, alm_hour_d;
  logic [5:0]    alm_cnt_q, alm_cnt_d;
  logic          alarm_q, alarm_d;
`endif

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] last);
    return (v == last) ? 6'd0 : v + 6'd1;
  endfunction

  always_comb begin
    presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    tick_d  = (presc_q == PRESC_LAST);
    blink_d = blink_q ^ ((presc_q == PRESC_HALF) || (presc_q == PRESC_LAST));
    mode_d  = mode_q;
    pos_d   = pos_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
`ifdef HMS_ALARM_EN
    alm_min_d  = alm_min_q;
    alm_hour_d = alm_hour_q;
    time_run   = (mode_q != MODE_SETUP);
`else
    time_run   = (mode_q == MODE_CLOCK);
`endif

    // Full carry chain resolves in one cycle, so 23:59:59 -> 00:00:00 is atomic.
    if (time_run && tick_q) begin
      sec_d = wrap_inc(sec_q, 6'd59);
      if (sec_q == 6'd59) begin
        min_d = wrap_inc(min_q, 6'd59);
        if (min_q == 6'd59) hour_d = wrap_inc(hour_q, HOUR_LAST);
      end
    end

    // Leaving SETUP restarts the second so the first running second is a full one.
    if (i_mode_pulse) begin
`ifdef HMS_ALARM_EN
      case (mode_q)
        MODE_CLOCK: begin
          mode_d = MODE_SETUP;
          pos_d  = 2'd0;
        end
        MODE_SETUP: begin
          mode_d  = MODE_ALARM;
          pos_d   = 2'd1;
          presc_d = '0;
          tick_d  = 1'b0;
          blink_d = 1'b0;
        end
        default: mode_d = MODE_CLOCK;
      endcase
`else
      if (mode_q == MODE_CLOCK) begin
        mode_d = MODE_SETUP;
        pos_d  = 2'd0;
      end else begin
        mode_d  = MODE_CLOCK;
        presc_d = '0;
        tick_d  = 1'b0;
        blink_d = 1'b0;
      end
`endif
    end else if (i_pos_pulse) begin
      if (mode_q == MODE_SETUP) begin
        pos_d = (pos_q == 2'd2) ? 2'd0 : pos_q + 2'd1;
      end
`ifdef HMS_ALARM_EN
      else if (mode_q == MODE_ALARM) begin
        pos_d = (pos_q == 2'd2) ? 2'd1 : 2'd2;
      end
`endif
    end else if (i_inc_pulse) begin
      if (mode_q == MODE_SETUP) begin
        case (pos_q)
          2'd0:    sec_d  = wrap_inc(sec_q, 6'd59);
          2'd1:    min_d  = wrap_inc(min_q, 6'd59);
          2'd2:    hour_d = wrap_inc(hour_q, HOUR_LAST);
          default: ;
        endcase
      end
`ifdef HMS_ALARM_EN
      else if (mode_q == MODE_ALARM) begin
        case (pos_q)
          2'd1:    alm_min_d  = wrap_inc(alm_min_q, 6'd59);
          2'd2:    alm_hour_d = wrap_inc(alm_hour_q, HOUR_LAST);
          default: ;
        endcase
      end
`endif
    end

`ifdef HMS_ALARM_EN
    alarm_d   = alarm_q;
    alm_cnt_d = alm_cnt_q;
    if (alarm_q && tick_q) begin
      if (alm_cnt_q == 6'd59) alarm_d = 1'b0;
      else                    alm_cnt_d = alm_cnt_q + 6'd1;
    end
    // Match against the freshly advanced time so the flag rises with hh:mm:00.
    if ((mode_q == MODE_CLOCK) && tick_q && (sec_d == 6'd0) &&
        (min_d == alm_min_q) && (hour_d == alm_hour_q)) begin
      alarm_d   = 1'b1;
      alm_cnt_d = 6'd0;
    end
    if (i_mode_pulse || i_pos_pulse) alarm_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_CLOCK;
      presc_q <= '0;
      tick_q  <= 1'b0;
      blink_q <= 1'b0;
      sec_q   <= 6'(SEC_INIT);
      min_q   <= 6'd0;
      hour_q  <= 6'd0;
      pos_q   <= 2'd0;
`ifdef HMS_ALARM_EN
      alm_min_q  <= 6'd0;
      alm_hour_q <= 6'd0;
      alm_cnt_q  <= 6'd0;
      alarm_q    <= 1'b0;
`endif
    end else begin
      mode_q  <= mode_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      blink_q <= blink_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      pos_q   <= pos_d;
`ifdef HMS_ALARM_EN
      alm_min_q  <= alm_min_d;
      alm_hour_q <= alm_hour_d;
      alm_cnt_q  <= alm_cnt_d;
      alarm_q    <= alarm_d;
`endif
    end
  end

  assign o_sec      = sec_q;
  assign o_min      = min_q;
  assign o_hour     = hour_q;
  assign o_mode     = mode_q;
  assign o_position = pos_q;
  assign o_sec_tick = tick_q;
  assign o_blink    = blink_q;
`ifdef HMS_ALARM_EN
  assign o_alm_hour = alm_hour_q;
  assign o_alm_min  = alm_min_q;
  assign o_alarm    = alarm_q;
`endif

endmodule

// File: tb/tb_hms_timekeeper.sv
// Directed bench for hms_timekeeper (CLK_DIV=4); a second instance with HOUR_MAX=11 shares the stimulus.
module tb_hms_timekeeper;
`ifdef HMS_ALARM_EN
  localparam int MW = 2;
`else
  localparam int MW = 1;
`endif
  localparam logic [MW-1:0] M_CLOCK = '0;
  localparam logic [MW-1:0] M_SETUP = MW'(1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode_p = 1'b0, pos_p = 1'b0, inc_p = 1'b0;
  logic [5:0] sec, min, hour, sec12, min12, hour12;
  logic [MW-1:0] mode, mode12;
  logic [1:0] pos, pos12;
  logic tick, blink, tick12, blink12;
`ifdef HMS_ALARM_EN
  logic [5:0] amin, ahour, amin12, ahour12;
  logic [0:0] alarm, alarm12;
`endif
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hms_timekeeper #(.CLK_DIV(4), .HOUR_MAX(23), .SEC_INIT(0)) dut (
    .clk(clk), .rst_n(rst_n), .i_mode_pulse(mode_p), .i_pos_pulse(pos_p), .i_inc_pulse(inc_p),
    .o_sec(sec), .o_min(min), .o_hour(hour), .o_mode(mode), .o_position(pos),
`ifdef HMS_ALARM_EN
    .o_alm_hour(ahour), .o_alm_min(amin), .o_alarm(alarm),
`endif
    .o_sec_tick(tick), .o_blink(blink));

  hms_timekeeper #(.CLK_DIV(4), .HOUR_MAX(11), .SEC_INIT(0)) dut12 (
    .clk(clk), .rst_n(rst_n), .i_mode_pulse(mode_p), .i_pos_pulse(pos_p), .i_inc_pulse(inc_p),
    .o_sec(sec12), .o_min(min12), .o_hour(hour12), .o_mode(mode12), .o_position(pos12),
`ifdef HMS_ALARM_EN
    .o_alm_hour(ahour12), .o_alm_min(amin12), .o_alarm(alarm12),
`endif
    .o_sec_tick(tick12), .o_blink(blink12));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic m, input logic p, input logic i, input int n);
    mode_p = m; pos_p = p; inc_p = i;
    repeat (n) step();
    mode_p = 1'b0; pos_p = 1'b0; inc_p = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({sec, min, hour} !== 18'd0) begin errors++; $display("FAIL reset_time got=%0d:%0d:%0d exp=0:0:0", hour, min, sec); end
    checks++;
    if ({mode, pos, tick, blink} !== '0) begin errors++; $display("FAIL reset_ctrl got mode=%0d pos=%0d tick=%0d blink=%0d exp all 0", mode, pos, tick, blink); end
    step(); step();
    checks++;
    if ({tick, sec} !== 7'd0) begin errors++; $display("FAIL reset_hold got tick=%0d sec=%0d exp 0", tick, sec); end
    rst_n = 1'b1;
  endtask

  task automatic test_tick();
    for (int k = 1; k <= 16; k++) begin
      step();
      checks++;
      if (tick !== logic'(k % 4 == 0)) begin errors++; $display("FAIL tick k=%0d got=%0d exp=%0d", k, tick, (k % 4 == 0)); end
      checks++;
      if (sec !== 6'((k - 1) / 4)) begin errors++; $display("FAIL tick_sec k=%0d got=%0d exp=%0d", k, sec, (k - 1) / 4); end
      checks++;
      if (blink !== logic'((k / 2) % 2)) begin errors++; $display("FAIL blink k=%0d got=%0d exp=%0d", k, blink, (k / 2) % 2); end
    end
  endtask

  task automatic test_preload_wrap();
    do_reset();
    pulse(1, 0, 0, 1);
    checks++;
    if (mode !== M_SETUP || pos !== 2'd0) begin errors++; $display("FAIL enter_setup got mode=%0d pos=%0d exp 1,0", mode, pos); end
    pulse(0, 0, 1, 58);
    pulse(0, 1, 0, 1);
    pulse(0, 0, 1, 59);
    pulse(0, 1, 0, 1);
    pulse(0, 0, 1, 23);
    checks++;
    if ({hour, min, sec} !== {6'd23, 6'd59, 6'd58}) begin errors++; $display("FAIL preload got=%0d:%0d:%0d exp=23:59:58", hour, min, sec); end
    checks++;
    if (hour12 !== 6'd11) begin errors++; $display("FAIL preload_h12 got=%0d exp=11", hour12); end
    repeat (3) step();
    pulse(1, 0, 0, 1);
    checks++;
    if (blink !== 1'b0) begin errors++; $display("FAIL exit_blink got=%0d exp=0", blink); end
    for (int c = 1; c <= 9; c++) begin
`ifdef HMS_ALARM_EN
      mode_p = (c == 1);
`endif
      step();
      mode_p = 1'b0;
      checks++;
      if (tick !== logic'(c == 4 || c == 8)) begin errors++; $display("FAIL exit_tick c=%0d got=%0d exp=%0d", c, tick, (c == 4 || c == 8)); end
      if (c == 5 || c == 8) begin
        checks++;
        if ({hour, min, sec} !== {6'd23, 6'd59, 6'd59}) begin errors++; $display("FAIL pre_wrap c=%0d got=%0d:%0d:%0d exp=23:59:59", c, hour, min, sec); end
      end
    end
    checks++;
    if ({hour, min, sec} !== 18'd0) begin errors++; $display("FAIL wrap24 got=%0d:%0d:%0d exp=0:0:0", hour, min, sec); end
    checks++;
    if ({hour12, min12, sec12} !== 18'd0) begin errors++; $display("FAIL wrap12 got=%0d:%0d:%0d exp=0:0:0", hour12, min12, sec12); end
    checks++;
    if (mode12 !== M_CLOCK || pos12 !== 2'd2 || tick12 !== 1'b0 || blink12 !== 1'b0) begin
      errors++; $display("FAIL wrap12_ctrl got mode=%0d pos=%0d tick=%0d blink=%0d exp 0,2,0,0", mode12, pos12, tick12, blink12);
    end
    repeat (4) step();
    checks++;
    if (sec !== 6'd1) begin errors++; $display("FAIL post_wrap_sec got=%0d exp=1", sec); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sec, min, hour, pos, tick} !== '0 || mode !== M_CLOCK) begin errors++; $display("FAIL async_reset got sec=%0d pos=%0d mode=%0d tick=%0d exp 0", sec, pos, mode, tick); end
    step();
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      checks++;
      if (tick !== logic'(c == 4)) begin errors++; $display("FAIL restart_tick c=%0d got=%0d exp=%0d", c, tick, (c == 4)); end
    end
    checks++;
    if (sec !== 6'd1) begin errors++; $display("FAIL restart_sec got=%0d exp=1", sec); end
  endtask

  task automatic test_setup();
    do_reset();
    pulse(1, 0, 0, 1);
    pulse(0, 1, 0, 1);
    checks++;
    if (pos !== 2'd1) begin errors++; $display("FAIL setup_pos1 got=%0d exp=1", pos); end
    pulse(0, 0, 1, 61);
    checks++;
    if ({hour, min, sec} !== {6'd0, 6'd1, 6'd0}) begin errors++; $display("FAIL setup_min61 got=%0d:%0d:%0d exp=0:1:0", hour, min, sec); end
    pulse(0, 1, 0, 1);
    checks++;
    if (pos !== 2'd2) begin errors++; $display("FAIL setup_pos2 got=%0d exp=2", pos); end
    pulse(0, 0, 1, 23);
    checks++;
    if (hour !== 6'd23 || hour12 !== 6'd11) begin errors++; $display("FAIL setup_h23 got=%0d/%0d exp=23/11", hour, hour12); end
    pulse(0, 0, 1, 1);
    checks++;
    if (hour !== 6'd0 || hour12 !== 6'd0 || min !== 6'd1) begin errors++; $display("FAIL setup_hwrap got h=%0d h12=%0d m=%0d exp 0,0,1", hour, hour12, min); end
    pulse(0, 1, 0, 1);
    checks++;
    if (pos !== 2'd0) begin errors++; $display("FAIL setup_poswrap got=%0d exp=0", pos); end
  endtask

  task automatic test_simultaneous();
    pulse(0, 1, 1, 1);
    checks++;
    if (pos !== 2'd1 || {hour, min, sec} !== {6'd0, 6'd1, 6'd0}) begin errors++; $display("FAIL pos_inc got pos=%0d time=%0d:%0d:%0d exp 1, 0:1:0", pos, hour, min, sec); end
    pulse(1, 0, 0, 1);
`ifdef HMS_ALARM_EN
    pulse(1, 0, 0, 1);
`endif
    checks++;
    if (mode !== M_CLOCK) begin errors++; $display("FAIL back_to_clock got=%0d exp=0", mode); end
    pulse(0, 1, 0, 1);
    checks++;
    if (pos !== 2'd1) begin errors++; $display("FAIL pos_in_clock got=%0d exp=1", pos); end
    pulse(1, 1, 1, 1);
    checks++;
    if (mode !== M_SETUP || pos !== 2'd0) begin errors++; $display("FAIL triple got mode=%0d pos=%0d exp 1,0", mode, pos); end
    checks++;
    if ({hour, min, sec} !== {6'd0, 6'd1, 6'd0}) begin errors++; $display("FAIL triple_time got=%0d:%0d:%0d exp=0:1:0", hour, min, sec); end
  endtask

`ifdef HMS_ALARM_EN
  task automatic test_alarm();
    logic prev;
    int n;
    do_reset();
    pulse(1, 0, 0, 1);
    pulse(1, 0, 0, 1);
    checks++;
    if (mode !== 2'd2 || pos !== 2'd1) begin errors++; $display("FAIL alm_enter got mode=%0d pos=%0d exp 2,1", mode, pos); end
    pulse(0, 0, 1, 1);
    pulse(1, 0, 0, 1);
    prev = 1'b1; n = 0;
    while (min != 6'd1 && n < 400) begin prev = alarm; step(); n++; end
    checks++;
    if (n >= 400 || sec !== 6'd0 || alarm !== 1'b1 || prev !== 1'b0 || alarm12 !== 1'b1) begin
      errors++; $display("FAIL alm_rise got alarm=%0d prev=%0d sec=%0d n=%0d exp 1,0,0", alarm, prev, sec, n);
    end
    pulse(0, 1, 0, 1);
    checks++;
    if (alarm !== 1'b0) begin errors++; $display("FAIL alm_pos_clear got=%0d exp=0", alarm); end
    pulse(1, 0, 0, 1);
    pulse(1, 0, 0, 1);
    pulse(0, 0, 1, 1);
    pulse(1, 0, 0, 1);
    checks++;
    if (amin !== 6'd2 || ahour !== 6'd0 || amin12 !== 6'd2 || ahour12 !== 6'd0) begin errors++; $display("FAIL alm_regs got=%0d:%0d exp=0:2", ahour, amin); end
    n = 0;
    while (alarm !== 1'b1 && n < 600) begin step(); n++; end
    checks++;
    if (n >= 600 || min !== 6'd2 || sec !== 6'd0) begin errors++; $display("FAIL alm_rise2 got=%0d:%0d n=%0d exp=2:0", min, sec, n); end
    n = 0;
    while (min != 6'd3 && n < 400) begin prev = alarm; step(); n++; end
    checks++;
    if (n >= 400 || prev !== 1'b1 || alarm !== 1'b0) begin errors++; $display("FAIL alm_timeout got prev=%0d alarm=%0d n=%0d exp 1,0", prev, alarm, n); end
  endtask
`endif

  initial begin
    test_reset();
    test_tick();
    test_preload_wrap();
    test_setup();
    test_simultaneous();
`ifdef HMS_ALARM_EN
    test_alarm();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
